// File: rtl/marin_pkg.sv
// Shared definitions for the Marin display controller: register map, CTRL layout,
// scan FSM encoding and small helpers used by the top level.
package marin_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;

    localparam int unsigned CTRL_EN_BIT    = 0;
    localparam int unsigned CTRL_BLANK_LSB = 4;
    localparam int unsigned CTRL_DP_LSB    = 8;
    localparam logic [15:0] CTRL_MASK      = 16'h0FF1;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ON    = 2'b01;
    localparam logic [1:0] ST_BLANK = 2'b10;

    function automatic logic [3:0] nibble_of(input logic [15:0] word, input logic [1:0] idx);
        logic [3:0] n;
        n = '0;
        case (idx)
            2'd0: n = word[3:0];
            2'd1: n = word[7:4];
            2'd2: n = word[11:8];
            2'd3: n = word[15:12];
            default: n = '0;
        endcase
        return n;
    endfunction

    function automatic logic [15:0] byte_merge(input logic [15:0] old_word,
                                               input logic [15:0] new_word,
                                               input logic [1:0]  sel);
        logic [15:0] w;
        w = old_word;
        if (sel[0]) w[7:0]  = new_word[7:0];
        if (sel[1]) w[15:8] = new_word[15:8];
        return w;
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}; purely combinational.
module hex7seg (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/marin_disp_ctrl.sv
// Wishbone slave holding the display word and control register, plus the digit-scan
// scheduler driving the shared active-low seg/an pins of a 4-digit display.
module marin_disp_ctrl
    import marin_pkg::*;
#(
    parameter int unsigned DIGIT_CYCLES = 50000,
    parameter int unsigned BLANK_CYCLES = 1000,
    parameter logic [15:0] CTRL_RESET   = 16'h0001
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [1:0]  wb_adr_i,
    input  logic [1:0]  wb_sel_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic [7:0]  seg,
    output logic [3:0]  an
);

    localparam int unsigned CW = $clog2(DIGIT_CYCLES);
    localparam int unsigned ON_CYCLES = DIGIT_CYCLES - BLANK_CYCLES;
    localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    logic [15:0]   data_reg;
    logic [15:0]   ctrl_reg;
    logic          accept;
    logic [15:0]   rdata;

    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic [1:0]    digit;
    logic [1:0]    digit_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          load;
    logic          enable;

    logic [3:0]    sh_nibble;
    logic          sh_blank;
    logic          sh_dp;
    logic [6:0]    hex_seg;

    // ------------------------------------------------------------------
    // Bus interface
    // ------------------------------------------------------------------
    assign accept = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign enable = ctrl_reg[CTRL_EN_BIT];

    always_comb begin
        rdata = '0;
        case (wb_adr_i)
            ADDR_DATA:   rdata = data_reg;
            ADDR_CTRL:   rdata = ctrl_reg & CTRL_MASK;
            ADDR_STATUS: rdata = {12'h000, state, digit};
            ADDR_RSVD:   rdata = '0;
            default:     rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            data_reg <= '0;
            ctrl_reg <= CTRL_RESET & CTRL_MASK;
        end else begin
            wb_ack_o <= accept;
            wb_dat_o <= (accept && !wb_we_i) ? rdata : '0;
            if (accept && wb_we_i) begin
                case (wb_adr_i)
                    ADDR_DATA: data_reg <= byte_merge(data_reg, wb_dat_i, wb_sel_i);
                    ADDR_CTRL: ctrl_reg <= byte_merge(ctrl_reg, wb_dat_i, wb_sel_i) & CTRL_MASK;
                    default:   ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan scheduler
    // ------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        digit_nx = digit;
        cnt_nx   = cnt + 1'b1;
        load     = 1'b0;
        if (!enable) begin
            state_nx = ST_IDLE;
            digit_nx = '0;
            cnt_nx   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nx = ST_ON;
                    digit_nx = '0;
                    cnt_nx   = '0;
                    load     = 1'b1;
                end
                ST_ON: begin
                    if (cnt == ON_LAST) begin
                        state_nx = ST_BLANK;
                        cnt_nx   = '0;
                    end
                end
                ST_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_nx = ST_ON;
                        digit_nx = digit + 2'd1;
                        cnt_nx   = '0;
                        load     = 1'b1;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                    digit_nx = '0;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    // Shadow is sampled with the incoming digit so a mid-slot register write waits for the next slot.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            digit     <= '0;
            cnt       <= '0;
            sh_nibble <= '0;
            sh_blank  <= 1'b0;
            sh_dp     <= 1'b0;
        end else begin
            state <= state_nx;
            digit <= digit_nx;
            cnt   <= cnt_nx;
            if (load) begin
                sh_nibble <= nibble_of(data_reg, digit_nx);
                sh_blank  <= ctrl_reg[CTRL_BLANK_LSB + 32'(digit_nx)];
                sh_dp     <= ctrl_reg[CTRL_DP_LSB + 32'(digit_nx)];
            end
        end
    end

    hex7seg u_hex7seg (
        .nibble (sh_nibble),
        .seg    (hex_seg)
    );

    // ------------------------------------------------------------------
    // Registered pin drivers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            an  <= 4'hF;
            seg <= 8'hFF;
        end else if (state == ST_ON) begin
            an  <= sh_blank ? 4'hF : ~(4'b0001 << digit);
            seg <= {~sh_dp, hex_seg};
        end else begin
            an  <= 4'hF;
            seg <= 8'hFF;
        end
    end

endmodule
